// File: rtl/rx_ext_ts_pkg.sv
// rx_ext_ts shared definitions: PTP field offsets, XGMII control codes,
// tsu_cfg bit positions, FSM state type and timestamp FIFO entry layout.
package rx_ext_ts_pkg;

   // PTP header offsets relative to PTP header byte 0
   localparam int PTP_MTS_OFFSET   = 16;
   localparam int PTP_SEQID_OFFSET = 30;

   // XGMII control characters
   localparam logic [7:0] XGMII_START = 8'hFB;
   localparam logic [7:0] XGMII_TERM  = 8'hFD;
   localparam logic [7:0] XGMII_ERR   = 8'hFE;

   // tsu_cfg_i bit positions
   localparam int TSU_CFG_EMB_BIT     = 5;
   localparam int TSU_CFG_RESTORE_BIT = 6;

   typedef enum logic {
      ST_IDLE,
      ST_IN_FRAME
   } rx_state_e;

   typedef struct packed {
      logic [15:0] seq_id;
      logic [3:0]  msg_type;
      logic [31:0] ns;
   } ts_entry_t;

   localparam int TS_W = $bits(ts_entry_t);

   // Byte position of a frame byte relative to the PTP header start
   function automatic logic [10:0] ptp_rel(
      input logic [10:0] idx,
      input logic [10:0] base
   );
      return idx - base;
   endfunction

endpackage

// File: rtl/rx_ts_fifo.sv
// rx_ts_fifo: synchronous first-word-fall-through FIFO with sticky overflow.
// Ports: push_i/push_data_i write, pop_i pops head, rd_data_o shows head,
//        empty_o, count_o (0..DEPTH), ovf_o sticky, ovf_clr_i clears it.
module rx_ts_fifo
   import rx_ext_ts_pkg::*;
#(
   parameter int W     = TS_W,
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic         rx_clk,
   input  logic         rx_rst_n,
   input  logic         push_i,
   input  logic [W-1:0] push_data_i,
   input  logic         pop_i,
   input  logic         ovf_clr_i,
   output logic [W-1:0] rd_data_o,
   output logic         empty_o,
   output logic [AW:0]  count_o,
   output logic         ovf_o
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   cnt_q;
   logic [AW:0]   cnt_d;
   logic          ovf_q;
   logic          ovf_d;
   logic          empty;
   logic          full;
   logic          do_push;
   logic          do_pop;
   logic          ovf_evt;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == (AW+1)'(DEPTH));
   assign do_pop  = pop_i & ~empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts
   assign do_push = push_i & (~full | do_pop);
   assign ovf_evt = push_i & full & ~do_pop;

   // New overflow beats a simultaneous clear
   assign ovf_d = (ovf_q & ~ovf_clr_i) | ovf_evt;

   always_comb begin
      cnt_d = cnt_q;
      unique case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge rx_clk or negedge rx_rst_n) begin
      if (!rx_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   always_ff @(posedge rx_clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

   // Storage is not reset; the head is masked while nothing valid is held
   assign rd_data_o = empty ? '0 : mem_q[rd_ptr_q];
   assign empty_o   = empty;
   assign count_o   = cnt_q;
   assign ovf_o     = ovf_q;

endmodule

// File: rtl/rx_ext_ts.sv
// rx_ext_ts: reads embedded PTP ingress timestamps on the xgmii rx path,
// optionally zeroes messageTypeSpecific, and queues {seqId,msgType,ns}.
// Ports: rxd_i/rxc_i/eth_count_base_i in, rxd_o/rxc_o/eth_count_base_o
//        out (1 enabled cycle later); ts_* is the timestamp FIFO read side.
module rx_ext_ts
   import rx_ext_ts_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int FIFO_AW    = 3
) (
   input  logic               rx_clk,
   input  logic               rx_rst_n,
   input  logic               rx_clk_en_i,
   input  logic [63:0]        rxd_i,
   input  logic [7:0]         rxc_i,
   input  logic [10:0]        eth_count_base_i,
   input  logic [10:0]        ptp_addr_base_i,
   input  logic [3:0]         ptp_messageType_i,
   input  logic               is_ptp_message_i,
   input  logic [31:0]        tsu_cfg_i,
   output logic [63:0]        rxd_o,
   output logic [7:0]         rxc_o,
   output logic [10:0]        eth_count_base_o,
   input  logic               ts_rd_en_i,
   output logic [TS_W-1:0]    ts_rd_data_o,
   output logic               ts_empty_o,
   output logic [FIFO_AW:0]   ts_count_o,
   output logic               ts_ovf_o,
   input  logic               ts_ovf_clr_i
);

   rx_state_e   state_q;
   logic [31:0] ns_q;
   logic [31:0] ns_d;
   logic [15:0] seq_q;
   logic [15:0] seq_d;
   logic [5:0]  vld_q;
   logic [5:0]  vld_d;
   logic [63:0] rxd_q;
   logic [63:0] rxd_d;
   logic [7:0]  rxc_q;
   logic [10:0] base_q;
   logic [10:0] off [8];
   logic        in_frame;
   logic        start_l0;
   logic        term_any;
   logic        err_any;
   logic        emb_en;
   logic        restore;
   logic        push;
   ts_entry_t   push_data;
   logic        unused_cfg;

   assign unused_cfg = ^{tsu_cfg_i[31:7], tsu_cfg_i[4:0]};

   assign in_frame = (state_q == ST_IN_FRAME);
   assign emb_en   = tsu_cfg_i[TSU_CFG_EMB_BIT] & is_ptp_message_i &
                     ~ptp_messageType_i[3];
   assign restore  = emb_en & tsu_cfg_i[TSU_CFG_RESTORE_BIT];
   assign start_l0 = rxc_i[0] & (rxd_i[7:0] == XGMII_START);

   always_comb begin
      for (int i = 0; i < 8; i++)
         off[i] = ptp_rel(eth_count_base_i + 11'(i), ptp_addr_base_i);
   end

   always_comb begin
      term_any = 1'b0;
      err_any  = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (rxc_i[i] && rxd_i[8*i +: 8] == XGMII_TERM) term_any = 1'b1;
         if (rxc_i[i] && rxd_i[8*i +: 8] == XGMII_ERR)  err_any  = 1'b1;
      end
   end

   // Byte capture and messageTypeSpecific restore. Lanes in front of a
   // terminate character in the same word are still captured, so the
   // push decision uses the _d view of the capture registers.
   always_comb begin
      ns_d  = ns_q;
      seq_d = seq_q;
      vld_d = vld_q;
      rxd_d = rxd_i;
      for (int i = 0; i < 8; i++) begin
         if (in_frame && !rxc_i[i]) begin
            case (off[i])
               11'(PTP_MTS_OFFSET): begin
                  ns_d[31:24] = rxd_i[8*i +: 8];
                  vld_d[0]    = 1'b1;
               end
               11'(PTP_MTS_OFFSET + 1): begin
                  ns_d[23:16] = rxd_i[8*i +: 8];
                  vld_d[1]    = 1'b1;
               end
               11'(PTP_MTS_OFFSET + 2): begin
                  ns_d[15:8] = rxd_i[8*i +: 8];
                  vld_d[2]   = 1'b1;
               end
               11'(PTP_MTS_OFFSET + 3): begin
                  ns_d[7:0] = rxd_i[8*i +: 8];
                  vld_d[3]  = 1'b1;
               end
               11'(PTP_SEQID_OFFSET): begin
                  seq_d[15:8] = rxd_i[8*i +: 8];
                  vld_d[4]    = 1'b1;
               end
               11'(PTP_SEQID_OFFSET + 1): begin
                  seq_d[7:0] = rxd_i[8*i +: 8];
                  vld_d[5]   = 1'b1;
               end
               default: ;
            endcase
            if (restore &&
                off[i] >= 11'(PTP_MTS_OFFSET) &&
                off[i] <= 11'(PTP_MTS_OFFSET + 3))
               rxd_d[8*i +: 8] = 8'h00;
         end
      end
   end

   // Error wins over terminate in the same word
   assign push = rx_clk_en_i & in_frame & term_any & ~err_any &
                 (&vld_d) & emb_en;

   assign push_data = '{seq_id:   seq_d,
                        msg_type: ptp_messageType_i,
                        ns:       ns_d};

   always_ff @(posedge rx_clk or negedge rx_rst_n) begin
      if (!rx_rst_n) begin
         state_q <= ST_IDLE;
         ns_q    <= '0;
         seq_q   <= '0;
         vld_q   <= '0;
         rxd_q   <= '0;
         rxc_q   <= '0;
         base_q  <= '0;
      end else if (rx_clk_en_i) begin
         rxd_q  <= rxd_d;
         rxc_q  <= rxc_i;
         base_q <= eth_count_base_i;
         ns_q   <= ns_d;
         seq_q  <= seq_d;
         vld_q  <= vld_d;
         unique case (state_q)
            ST_IDLE: begin
               if (start_l0) begin
                  state_q <= ST_IN_FRAME;
                  vld_q   <= '0;
               end
            end
            ST_IN_FRAME: begin
               if (err_any || term_any) begin
                  state_q <= ST_IDLE;
               end else if (start_l0) begin
                  // Start without terminate: drop the partial capture
                  vld_q <= '0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign rxd_o            = rxd_q;
   assign rxc_o            = rxc_q;
   assign eth_count_base_o = base_q;

   rx_ts_fifo #(
      .W     (TS_W),
      .DEPTH (FIFO_DEPTH),
      .AW    (FIFO_AW)
   ) u_fifo (
      .rx_clk      (rx_clk),
      .rx_rst_n    (rx_rst_n),
      .push_i      (push),
      .push_data_i (push_data),
      .pop_i       (ts_rd_en_i),
      .ovf_clr_i   (ts_ovf_clr_i),
      .rd_data_o   (ts_rd_data_o),
      .empty_o     (ts_empty_o),
      .count_o     (ts_count_o),
      .ovf_o       (ts_ovf_o)
   );

endmodule
